// File: rtl/dl_adder_pkg.sv
// dl_adder_pkg: shared helpers for the dl adder family.
// Chunk sizing, configuration legality and the signed overflow test.
package dl_adder_pkg;

    localparam int DL_DEF_BITS   = 32;
    localparam int DL_DEF_STAGES = 4;

    function automatic int dl_chunk_w(input int num_bits,
                                      input int num_stages);
        return (num_stages > 0) ? num_bits / num_stages : num_bits;
    endfunction

    function automatic bit dl_cfg_ok(input int num_bits,
                                     input int num_stages);
        if (num_stages < 1 || num_stages > num_bits)
            return 1'b0;
        return (num_bits % num_stages) == 0;
    endfunction

    // Same-sign operands producing an opposite-sign result.
    function automatic logic dl_ovf(input logic a_msb,
                                    input logic b_msb,
                                    input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/dl_pipe_adder_if.sv
// dl_pipe_adder_if: operand and result handshakes of the pipelined adder.
// master drives operands and out_ready; slave is the adder.
interface dl_pipe_adder_if
    import dl_adder_pkg::*;
#(
    parameter int NUM_BITS = DL_DEF_BITS
);
    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] a;
    logic [NUM_BITS-1:0] b;
    logic                cin;
    logic                sub;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_BITS-1:0] sum;
    logic                cout;
    logic                ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/dl_pipe_adder_stage.sv
// dl_pipe_adder_stage: one CW-bit chunk of the carry chain plus its
// pipeline register and stall logic.
module dl_pipe_adder_stage
    import dl_adder_pkg::*;
#(
    parameter int NUM_BITS = DL_DEF_BITS,
    parameter int CW       = DL_DEF_BITS / DL_DEF_STAGES,
    parameter int IDX      = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up_valid,
    input  logic [NUM_BITS-1:0] up_a,
    input  logic [NUM_BITS-1:0] up_b,
    input  logic [NUM_BITS-1:0] up_s,
    input  logic                up_c,
    input  logic                up_ovf,
    input  logic                down_adv,
    output logic                adv,
    output logic                valid,
    output logic [NUM_BITS-1:0] a,
    output logic [NUM_BITS-1:0] b,
    output logic [NUM_BITS-1:0] s,
    output logic                c,
    output logic                ovf
);
    localparam int LO   = IDX * CW;
    localparam bit LAST = ((IDX + 1) * CW) == NUM_BITS;

    logic [CW:0]         part;
    logic [NUM_BITS-1:0] s_next;
    logic                ovf_next;

    assign part = {1'b0, up_a[LO +: CW]}
                + {1'b0, up_b[LO +: CW]}
                + {{CW{1'b0}}, up_c};

    always_comb begin
        s_next          = up_s;
        s_next[LO +: CW] = part[CW-1:0];
    end

    // Only the top chunk sees the sum MSB; lower stages pass zero along.
    assign ovf_next = LAST ? dl_ovf(up_a[NUM_BITS-1],
                                    up_b[NUM_BITS-1],
                                    part[CW-1])
                           : up_ovf;

    assign adv = !valid || down_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            a     <= '0;
            b     <= '0;
            s     <= '0;
            c     <= 1'b0;
            ovf   <= 1'b0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                a   <= up_a;
                b   <= up_b;
                s   <= s_next;
                c   <= part[CW];
                ovf <= ovf_next;
            end
        end
    end
endmodule

// File: rtl/dl_pipe_adder.sv
// dl_pipe_adder: add/subtract with the carry chain split over
// NUM_STAGES registered chunks and a valid/ready handshake.
module dl_pipe_adder
    import dl_adder_pkg::*;
#(
    parameter int NUM_BITS   = DL_DEF_BITS,
    parameter int NUM_STAGES = DL_DEF_STAGES
) (
    input logic            clk,
    input logic            rst,
    dl_pipe_adder_if.slave bus
);
    localparam int CW = dl_chunk_w(NUM_BITS, NUM_STAGES);

    if (!dl_cfg_ok(NUM_BITS, NUM_STAGES)) begin : g_bad_cfg
        $error("dl_pipe_adder: NUM_STAGES must divide NUM_BITS");
    end

    logic                valid_p [0:NUM_STAGES];
    logic                adv_p   [0:NUM_STAGES];
    logic [NUM_BITS-1:0] a_p     [0:NUM_STAGES];
    logic [NUM_BITS-1:0] b_p     [0:NUM_STAGES];
    logic [NUM_BITS-1:0] s_p     [0:NUM_STAGES];
    logic                c_p     [0:NUM_STAGES];
    logic                ovf_p   [0:NUM_STAGES];
    logic                unused_tail;

    // Subtraction is a + ~b + 1; cin is ignored then.
    assign valid_p[0] = bus.in_valid;
    assign a_p[0]     = bus.a;
    assign b_p[0]     = bus.sub ? ~bus.b : bus.b;
    assign s_p[0]     = '0;
    assign c_p[0]     = bus.sub | bus.cin;
    assign ovf_p[0]   = 1'b0;

    assign adv_p[NUM_STAGES] = bus.out_ready;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        dl_pipe_adder_stage #(
            .NUM_BITS (NUM_BITS),
            .CW       (CW),
            .IDX      (k)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (valid_p[k]),
            .up_a     (a_p[k]),
            .up_b     (b_p[k]),
            .up_s     (s_p[k]),
            .up_c     (c_p[k]),
            .up_ovf   (ovf_p[k]),
            .down_adv (adv_p[k+1]),
            .adv      (adv_p[k]),
            .valid    (valid_p[k+1]),
            .a        (a_p[k+1]),
            .b        (b_p[k+1]),
            .s        (s_p[k+1]),
            .c        (c_p[k+1]),
            .ovf      (ovf_p[k+1])
        );
    end

    assign bus.in_ready  = adv_p[0] | rst;
    assign bus.out_valid = valid_p[NUM_STAGES];
    assign bus.sum       = s_p[NUM_STAGES];
    assign bus.cout      = c_p[NUM_STAGES];
    assign bus.ovf       = ovf_p[NUM_STAGES];

    // Operand copies leaving the last stage have no consumer.
    assign unused_tail = ^{a_p[NUM_STAGES], b_p[NUM_STAGES]};
endmodule
